// File: rtl/aes_byte_stream_loader_if.sv
// aes_byte_stream_loader_if
//   Bundles the byte-stream handshakes and the 128-bit core-facing buses of
//   aes_byte_stream_loader.
//   slave  : the loader itself. It drives in_ready, core_key, core_data,
//            out_byte, out_valid, busy and dbg_state.
//   master : the environment, which is the byte source, the core and the byte sink.
//   Signals:
//     in_byte[7:0], in_is_key, in_valid, in_ready      input byte stream
//     core_key[127:0], core_data[127:0]                 to core IN_KEY / IN_DATA
//     core_result[127:0]                                from core OUT_DATA
//     out_byte[7:0], out_valid, out_ready               ciphertext byte stream
//     busy                                              high while WAIT or DRAIN
//     dbg_state[1:0]                                    current FSM state
`timescale 1ns/1ps
interface aes_byte_stream_loader_if;
   logic [7:0]   in_byte;
   logic         in_is_key;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] core_key;
   logic [127:0] core_data;
   logic [127:0] core_result;
   logic [7:0]   out_byte;
   logic         out_valid;
   logic         out_ready;
   logic         busy;
   logic [1:0]   dbg_state;

   modport slave (
      input  in_byte, in_is_key, in_valid, core_result, out_ready,
      output in_ready, core_key, core_data, out_byte, out_valid, busy, dbg_state
   );

   modport master (
      output in_byte, in_is_key, in_valid, core_result, out_ready,
      input  in_ready, core_key, core_data, out_byte, out_valid, busy, dbg_state
   );
endinterface

// File: rtl/aes_byte_stream_loader.sv
// aes_byte_stream_loader
//   Byte-serial front end for the MODIFIED_AES128_V2 core. The loader builds
//   16-byte key and data blocks from an input byte stream and holds them stable
//   on core_key and core_data. It waits CORE_LATENCY cycles, captures
//   core_result, and then streams the 16 result bytes out, MSB byte first.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  aes_byte_stream_loader_if.slave (byte streams, core buses, busy,
//          dbg_state)
//
//   Handshake rule for both byte streams: a byte moves on a rising edge where
//   valid && ready. A sender holds its byte and valid steady until that edge.
//   ready is not a condition for asserting valid. out_byte and out_valid are
//   registered and stay unchanged while out_ready is low.
`timescale 1ns/1ps
module aes_byte_stream_loader #(
   parameter int unsigned CORE_LATENCY = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   aes_byte_stream_loader_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_INIT = 8'(CORE_LATENCY - 1);

   state_t         r_state;
   logic [127:0]   r_key_asm;
   logic [127:0]   r_data_asm;
   logic [3:0]     r_key_cnt;
   logic [4:0]     r_data_cnt;
   logic           r_key_valid;
   logic [127:0]   r_core_key;
   logic [127:0]   r_core_data;
   logic [7:0]     r_wait_cnt;
   logic [127:0]   r_shift;
   logic [3:0]     r_out_cnt;
   logic           r_out_valid;

   logic           w_data_full;
   logic           w_in_ready;
   logic           w_key_acc;
   logic           w_data_acc;
   logic [127:0]   w_key_asm_nxt;
   logic [127:0]   w_data_asm_nxt;
   logic           w_key_done;
   logic [3:0]     w_key_cnt_nxt;
   logic [4:0]     w_data_cnt_nxt;
   logic           w_key_valid_nxt;
   logic           w_launch;
   logic           w_out_hs;

   // A full data buffer blocks only data bytes. Key bytes still get through,
   // which is how a key sent after the data can release the launch.
   assign w_data_full = (r_data_cnt == 5'd16);
   assign w_in_ready  = (r_state == ST_LOAD) && !(w_data_full && !bus.in_is_key);
   assign w_key_acc   = bus.in_valid && w_in_ready && bus.in_is_key;
   assign w_data_acc  = bus.in_valid && w_in_ready && !bus.in_is_key;

   assign w_key_asm_nxt  = w_key_acc  ? {r_key_asm[119:0],  bus.in_byte} : r_key_asm;
   assign w_data_asm_nxt = w_data_acc ? {r_data_asm[119:0], bus.in_byte} : r_data_asm;
   assign w_key_done     = w_key_acc && (r_key_cnt == 4'd15);
   assign w_key_cnt_nxt  = r_key_cnt + {3'd0, w_key_acc};
   assign w_data_cnt_nxt = r_data_cnt + {4'd0, w_data_acc};
   assign w_key_valid_nxt = r_key_valid || w_key_done;

   // The launch test uses post-edge values. A block can then launch on the
   // same edge that accepts its 16th data byte or 16th key byte. A partly
   // loaded new key (count not back at 0) holds the launch.
   assign w_launch = (r_state == ST_LOAD) && (w_data_cnt_nxt == 5'd16) &&
                     w_key_valid_nxt && (w_key_cnt_nxt == 4'd0);

   assign w_out_hs = r_out_valid && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_LOAD;
         r_key_asm   <= '0;
         r_data_asm  <= '0;
         r_key_cnt   <= '0;
         r_data_cnt  <= '0;
         r_key_valid <= 1'b0;
         r_core_key  <= '0;
         r_core_data <= '0;
         r_wait_cnt  <= '0;
         r_shift     <= '0;
         r_out_cnt   <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               r_key_asm  <= w_key_asm_nxt;
               r_key_cnt  <= w_key_cnt_nxt;
               r_data_asm <= w_data_asm_nxt;
               if (w_key_done) begin
                  r_core_key  <= w_key_asm_nxt;
                  r_key_valid <= 1'b1;
               end
               if (w_launch) begin
                  r_core_data <= w_data_asm_nxt;
                  r_data_cnt  <= '0;
                  r_wait_cnt  <= WAIT_INIT;
                  r_state     <= ST_WAIT;
               end else begin
                  r_data_cnt  <= w_data_cnt_nxt;
               end
            end
            ST_WAIT: begin
               // core_result is sampled CORE_LATENCY edges after the launch edge.
               if (r_wait_cnt == 8'd0) begin
                  r_shift     <= bus.core_result;
                  r_out_cnt   <= '0;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DRAIN;
               end else begin
                  r_wait_cnt  <= r_wait_cnt - 8'd1;
               end
            end
            ST_DRAIN: begin
               if (w_out_hs) begin
                  r_shift   <= {r_shift[119:0], 8'h00};
                  r_out_cnt <= r_out_cnt + 4'd1;
                  if (r_out_cnt == 4'd15) begin
                     r_out_valid <= 1'b0;
                     r_state     <= ST_LOAD;
                  end
               end
            end
            default: r_state <= ST_LOAD;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.core_key  = r_core_key;
   assign bus.core_data = r_core_data;
   assign bus.out_byte  = r_shift[127:120];
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
   assign bus.dbg_state = r_state;

endmodule
